gpr_file: RTL and testbench

- General-purpose register file that is the sink of the writeback mux. It accepts the selected rd data and write enable from writeback.
- Serves two combinational source-operand reads (rs1, rs2) to decode/execute, with same-cycle write-to-read bypass.
- Keeps a per-register pending-write scoreboard for long-latency results (loads). It raises a stall when an issuing instruction reads a register whose load has not yet written back.

---
 rtl/gpr_file_pkg.sv | 8 +
 rtl/gpr_scoreboard.sv | 55 +++++
 rtl/gpr_file.sv | 73 +++++++
 tb/tb_gpr_file.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/gpr_file_pkg.sv
// Shared sizing constants for the register file, its scoreboard and the decoder.
package gpr_file_pkg;

    localparam int REG_LEN    = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;

endpackage

// File: rtl/gpr_scoreboard.sv
// Pending-write scoreboard for long-latency (load) destinations.
// Raises stall when an issuing instruction reads a register whose load is still outstanding.
module gpr_scoreboard
    import gpr_file_pkg::*;
#(
    parameter int NUM_REGS = gpr_file_pkg::NUM_REGS,
    parameter int ADDR_W   = gpr_file_pkg::REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_we,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic              rs1_en,
    input  logic              rs2_en,
    input  logic              issue_valid,
    input  logic              issue_long,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              stall,
    output logic [ADDR_W:0]   busy_cnt
);

    logic [NUM_REGS-1:0] busy, busy_nxt;
    logic [ADDR_W:0]     cnt_nxt;
    logic                haz1, haz2;

    // A register retiring this cycle is served by the bypass path, so it never stalls.
    assign haz1  = rs1_en && busy[rs1_addr] && (rs1_addr != '0) && !(rd_we && rd_addr == rs1_addr);
    assign haz2  = rs2_en && busy[rs2_addr] && (rs2_addr != '0) && !(rd_we && rd_addr == rs2_addr);
    assign stall = issue_valid && (haz1 || haz2);

    // Clear is applied before set so a new load to the retiring register stays pending.
    always_comb begin
        busy_nxt = busy;
        if (rd_we && rd_addr != '0)
            busy_nxt[rd_addr] = 1'b0;
        if (issue_valid && !stall && issue_long && issue_rd != '0)
            busy_nxt[issue_rd] = 1'b1;
        cnt_nxt = '0;
        for (int i = 0; i < NUM_REGS; i++)
            cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/gpr_file.sv
// General-purpose register file: writeback sink, two bypassed combinational read
// ports, and a load scoreboard that produces the decode stall.
module gpr_file
    import gpr_file_pkg::*;
#(
    parameter int REG_LEN  = gpr_file_pkg::REG_LEN,
    parameter int NUM_REGS = gpr_file_pkg::NUM_REGS,
    parameter int ADDR_W   = gpr_file_pkg::REG_ADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_we,
    input  logic [ADDR_W-1:0]  rd_addr,
    input  logic [REG_LEN-1:0] rd_d,
    input  logic [ADDR_W-1:0]  rs1_addr,
    input  logic [ADDR_W-1:0]  rs2_addr,
    input  logic               rs1_en,
    input  logic               rs2_en,
    output logic [REG_LEN-1:0] rs1_d,
    output logic [REG_LEN-1:0] rs2_d,
    input  logic               issue_valid,
    input  logic               issue_long,
    input  logic [ADDR_W-1:0]  issue_rd,
    output logic               stall,
    output logic [ADDR_W:0]    busy_cnt
);

    logic [REG_LEN-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (rd_we && rd_addr != '0) begin
            regs[rd_addr] <= rd_d;
        end
    end

    // x0 wins over bypass so a writeback aimed at x0 can never leak through.
    always_comb begin
        rs1_d = regs[rs1_addr];
        if (rs1_addr == '0)
            rs1_d = '0;
        else if (rd_we && rd_addr == rs1_addr)
            rs1_d = rd_d;

        rs2_d = regs[rs2_addr];
        if (rs2_addr == '0)
            rs2_d = '0;
        else if (rd_we && rd_addr == rs2_addr)
            rs2_d = rd_d;
    end

    gpr_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_we       (rd_we),
        .rd_addr     (rd_addr),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_en      (rs1_en),
        .rs2_en      (rs2_en),
        .issue_valid (issue_valid),
        .issue_long  (issue_long),
        .issue_rd    (issue_rd),
        .stall       (stall),
        .busy_cnt    (busy_cnt)
    );

endmodule

// File: tb/tb_gpr_file.sv
// Directed vector table for the documented scenarios, an async-reset corner case,
// then randomized traffic against an array-based reference model.
module tb_gpr_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_d;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rs1_en, rs2_en;
    logic [31:0] rs1_d, rs2_d;
    logic        issue_valid, issue_long;
    logic [4:0]  issue_rd;
    logic        stall;
    logic [5:0]  busy_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gpr_file dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_we       (rd_we),
        .rd_addr     (rd_addr),
        .rd_d        (rd_d),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_en      (rs1_en),
        .rs2_en      (rs2_en),
        .rs1_d       (rs1_d),
        .rs2_d       (rs2_d),
        .issue_valid (issue_valid),
        .issue_long  (issue_long),
        .issue_rd    (issue_rd),
        .stall       (stall),
        .busy_cnt    (busy_cnt)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  a1, a2;
        logic        e1, e2, iv, il;
        logic [4:0]  ird;
        logic [31:0] x1, x2;
        logic        xs;
        logic [5:0]  xc;
    } vec_t;

    vec_t tv[15];

    // Reference model state
    logic [31:0] m_regs [32];
    bit          m_busy [32];

    function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd,
                                logic [4:0] a1, logic e1, logic [4:0] a2, logic e2,
                                logic iv, logic il, logic [4:0] ird,
                                logic [31:0] x1, logic [31:0] x2, logic xs, logic [5:0] xc);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd;
        v.a1 = a1; v.e1 = e1; v.a2 = a2; v.e2 = e2;
        v.iv = iv; v.il = il; v.ird = ird;
        v.x1 = x1; v.x2 = x2; v.xs = xs; v.xc = xc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] a1, input logic e1, input logic [4:0] a2, input logic e2,
                         input logic iv, input logic il, input logic [4:0] ird);
        rd_we = we; rd_addr = wa; rd_d = wd;
        rs1_addr = a1; rs1_en = e1; rs2_addr = a2; rs2_en = e2;
        issue_valid = iv; issue_long = il; issue_rd = ird;
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (rd_we && rd_addr == a) return rd_d;
        return m_regs[a];
    endfunction

    function automatic logic exp_stall();
        bit waits1, waits2;
        waits1 = rs1_en && rs1_addr != 0 && m_busy[rs1_addr] && !(rd_we && rd_addr == rs1_addr);
        waits2 = rs2_en && rs2_addr != 0 && m_busy[rs2_addr] && !(rd_we && rd_addr == rs2_addr);
        return issue_valid && (waits1 || waits2);
    endfunction

    function automatic int exp_cnt();
        int n = 0;
        foreach (m_busy[i]) if (m_busy[i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        foreach (m_regs[i]) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Retire the writeback first, then record the new load, so a same-index set survives.
    task automatic model_clock(input logic st);
        if (rd_we && rd_addr != 0) begin
            m_regs[rd_addr] = rd_d;
            m_busy[rd_addr] = 1'b0;
        end
        if (issue_valid && !st && issue_long && issue_rd != 0)
            m_busy[issue_rd] = 1'b1;
    endtask

    initial begin
        //            we wa  wd            a1 e1 a2 e2 iv il ird  x1            x2            xs xc
        tv[0]  = mk(0, 0,  32'h0,        5, 0, 0, 0, 0, 0, 0,  32'h0,        32'h0,        0, 0);
        tv[1]  = mk(1, 3,  32'hDEADBEEF, 3, 0, 0, 0, 0, 0, 0,  32'hDEADBEEF, 32'h0,        0, 0);
        tv[2]  = mk(1, 0,  32'h1234,     3, 0, 0, 0, 0, 0, 0,  32'hDEADBEEF, 32'h0,        0, 0);
        tv[3]  = mk(1, 7,  32'hA5A5A5A5, 7, 0, 3, 0, 0, 0, 0,  32'hA5A5A5A5, 32'hDEADBEEF, 0, 0);
        tv[4]  = mk(0, 0,  32'h0,        7, 0, 0, 0, 1, 1, 10, 32'hA5A5A5A5, 32'h0,        0, 0);
        tv[5]  = mk(0, 0,  32'h0,        3, 0, 10, 1, 1, 0, 1, 32'hDEADBEEF, 32'h0,        1, 1);
        tv[6]  = mk(1, 10, 32'h55,       3, 0, 10, 1, 1, 0, 1, 32'hDEADBEEF, 32'h55,       0, 1);
        tv[7]  = mk(0, 0,  32'h0,        3, 0, 10, 0, 0, 0, 0, 32'hDEADBEEF, 32'h55,       0, 0);
        tv[8]  = mk(0, 0,  32'h0,        12, 0, 0, 0, 1, 1, 12, 32'h0,       32'h0,        0, 0);
        tv[9]  = mk(1, 12, 32'h77,       12, 1, 0, 0, 1, 1, 12, 32'h77,      32'h0,        0, 1);
        tv[10] = mk(0, 0,  32'h0,        12, 1, 0, 0, 0, 0, 0,  32'h77,      32'h0,        0, 1);
        tv[11] = mk(0, 0,  32'h0,        12, 1, 0, 0, 1, 0, 0,  32'h77,      32'h0,        1, 1);
        tv[12] = mk(0, 0,  32'h0,        0, 1, 0, 0, 1, 1, 0,  32'h0,        32'h0,        0, 1);
        tv[13] = mk(1, 12, 32'h88,       0, 0, 0, 0, 1, 1, 4,  32'h0,        32'h0,        0, 1);
        tv[14] = mk(0, 0,  32'h0,        4, 1, 12, 1, 1, 0, 0, 32'h0,        32'h88,       1, 1);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 drive(0, 0, 0, 5, 0, 0, 0, 0, 0, 0);
        check("reset_stall", 32'(stall), 32'h0);
        check("reset_cnt", 32'(busy_cnt), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;

        for (int i = 0; i < 15; i++) begin
            drive(tv[i].we, tv[i].wa, tv[i].wd, tv[i].a1, tv[i].e1, tv[i].a2, tv[i].e2,
                  tv[i].iv, tv[i].il, tv[i].ird);
            @(negedge clk);
            check($sformatf("v%0d_rs1_d", i), rs1_d, tv[i].x1);
            check($sformatf("v%0d_rs2_d", i), rs2_d, tv[i].x2);
            check($sformatf("v%0d_stall", i), 32'(stall), 32'(tv[i].xs));
            check($sformatf("v%0d_busy_cnt", i), 32'(busy_cnt), 32'(tv[i].xc));
            if (i < 14) @(posedge clk) #1;
        end

        // Async reset between edges while x4 is pending and decode is stalled.
        #1 rst_n = 1'b0;
        #1;
        rs1_addr = 5'd3;
        #1;
        check("arst_stall", 32'(stall), 32'h0);
        check("arst_cnt", 32'(busy_cnt), 32'h0);
        check("arst_rs1_x3", rs1_d, 32'h0);
        check("arst_rs2_x12", rs2_d, 32'h0);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk) #1;

        for (int c = 0; c < 400; c++) begin
            logic st;
            drive(($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
                  ($urandom_range(0, 9) < 7), 1'($urandom), 5'($urandom_range(0, 7)));
            @(negedge clk);
            st = exp_stall();
            check($sformatf("rnd%0d_rs1_d", c), rs1_d, exp_read(rs1_addr));
            check($sformatf("rnd%0d_rs2_d", c), rs2_d, exp_read(rs2_addr));
            check($sformatf("rnd%0d_stall", c), 32'(stall), 32'(st));
            check($sformatf("rnd%0d_busy_cnt", c), 32'(busy_cnt), 32'(exp_cnt()));
            model_clock(st);
            @(posedge clk) #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
